// File: rtl/cp0_unit.sv
// Coprocessor-0 for the 5-stage MIPS pipeline: SR, Cause, EPC, PRId.
// Raises Req to flush the pipeline on interrupts and M-stage exceptions.
module cp0_unit #(
    parameter logic [31:0] PRID_VAL = 32'h2021_0007,
    parameter logic [5:0]  IM_RESET = 6'b111111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        We,
    input  logic [31:0] PC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        Req,
    output logic [31:0] EPCOut,
    output logic [31:0] DOut
);

    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exc_code;
    logic [31:2] epc;

    logic        int_req;
    logic        exc_req;
    logic [31:0] victim;
    logic        unused_ok;

    assign int_req   = (|(HWInt & im)) & ie & ~exl;
    assign exc_req   = (ExcCodeIn != 5'd0) & ~exl;
    assign Req       = reset & (int_req | exc_req);
    assign victim    = BDIn ? (PC - 32'd4) : PC;
    assign unused_ok = ^victim[1:0];
    assign EPCOut    = {epc, 2'b00};

    // Register update: reset, exception entry, then mtc0/eret.
    always_ff @(posedge clk) begin
        if (!reset) begin
            im       <= IM_RESET;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= 6'd0;
            exc_code <= 5'd0;
            epc      <= '0;
        end else begin
            ip <= HWInt;
            if (Req) begin
                exl      <= 1'b1;
                exc_code <= int_req ? 5'd0 : ExcCodeIn;
                bd       <= BDIn;
                epc      <= victim[31:2];
            end else begin
                if (We && A2 == 5'd12) begin
                    im  <= DIn[15:10];
                    exl <= DIn[1];
                    ie  <= DIn[0];
                end
                if (We && A2 == 5'd14) begin
                    epc <= DIn[31:2];
                end
                if (EXLClr) begin
                    exl <= 1'b0;
                end
            end
        end
    end

    // mfc0 read mux, registered values only.
    always_comb begin
        DOut = 32'd0;
        case (A1)
            5'd12:   DOut = {16'd0, im, 8'd0, exl, ie};
            5'd13:   DOut = {bd, 15'd0, ip, 3'd0, exc_code, 2'd0};
            5'd14:   DOut = {epc, 2'b00};
            5'd15:   DOut = PRID_VAL;
            default: DOut = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: directed scenarios, then random traffic
// against a register-image reference model.
module tb_cp0_unit;

    localparam logic [31:0] PRID   = 32'h2021_0007;
    localparam logic [5:0]  IM_RST = 6'h3F;

    logic        clk;
    logic        reset;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        We;
    logic [31:0] PC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        Req;
    logic [31:0] EPCOut;
    logic [31:0] DOut;

    int total = 0;
    int bad   = 0;
    bit known = 0;

    logic [31:0] m_sr;
    logic [31:0] m_cause;
    logic [31:0] m_epc;

    cp0_unit #(
        .PRID_VAL(PRID),
        .IM_RESET(IM_RST)
    ) dut (
        .clk(clk),
        .reset(reset),
        .A1(A1),
        .A2(A2),
        .DIn(DIn),
        .We(We),
        .PC(PC),
        .BDIn(BDIn),
        .ExcCodeIn(ExcCodeIn),
        .HWInt(HWInt),
        .EXLClr(EXLClr),
        .Req(Req),
        .EPCOut(EPCOut),
        .DOut(DOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic bit m_int();
        return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic bit m_req();
        bit exc;
        exc = (ExcCodeIn != 5'd0) && !m_sr[1];
        return reset && (m_int() || exc);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'd0;
        endcase
    endfunction

    function automatic void m_update();
        bit rq;
        bit intr;
        logic [31:0] v;
        rq   = m_req();
        intr = m_int();
        if (!reset) begin
            m_sr    = {16'd0, IM_RST, 10'd0};
            m_cause = 32'd0;
            m_epc   = 32'd0;
        end else begin
            m_cause[15:10] = HWInt;
            if (rq) begin
                m_sr[1]       = 1'b1;
                m_cause[31]   = BDIn;
                m_cause[6:2]  = intr ? 5'd0 : ExcCodeIn;
                v             = BDIn ? PC - 32'd4 : PC;
                m_epc         = v & 32'hFFFF_FFFC;
            end else begin
                if (We && A2 == 5'd12) m_sr = DIn & 32'h0000_FC03;
                if (We && A2 == 5'd14) m_epc = DIn & 32'hFFFF_FFFC;
                if (EXLClr) m_sr[1] = 1'b0;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp,
                      input string tag);
        A1 = a;
        #1;
        chk(tag, DOut, exp);
    endtask

    // Compare against the model, then advance one clock.
    task automatic step();
        #1;
        chk("req", {31'd0, Req}, {31'd0, m_req()});
        if (known) begin
            chk("dout", DOut, m_read(A1));
            chk("epcout", EPCOut, m_epc);
        end
        @(posedge clk);
        m_update();
        if (!reset) known = 1;
        #1;
    endtask

    task automatic idle();
        We = 0; EXLClr = 0; ExcCodeIn = 0; HWInt = 0;
        BDIn = 0; DIn = 0; A2 = 0; PC = 32'h0000_3000;
    endtask

    initial begin
        reset = 0; A1 = 5'd12; idle();
        HWInt = 6'h3F; ExcCodeIn = 5'd4;
        step();
        step();
        chk("rst_req", {31'd0, Req}, 32'd0);
        rd(5'd12, 32'h0000_FC00, "rst_sr");
        rd(5'd13, 32'h0000_0000, "rst_cause");
        rd(5'd15, PRID, "rst_prid");
        reset = 1; idle();
        step();

        ExcCodeIn = 5'd10; BDIn = 1; PC = 32'h0000_3010;
        #1 chk("ds_req", {31'd0, Req}, 32'd1);
        step();
        idle();
        #1 chk("ds_epc", EPCOut, 32'h0000_300C);
        rd(5'd13, 32'h8000_0028, "ds_cause");
        rd(5'd12, 32'h0000_FC02, "ds_sr");
        chk("ds_req0", {31'd0, Req}, 32'd0);

        EXLClr = 1; step(); idle();
        We = 1; A2 = 5'd12; DIn = 32'h0000_0401; step(); idle();
        HWInt = 6'h01; ExcCodeIn = 5'd12; PC = 32'h0000_3004;
        #1 chk("pri_req", {31'd0, Req}, 32'd1);
        step(); idle();
        HWInt = 6'h01;
        rd(5'd13, 32'h0000_0400, "pri_cause");
        chk("pri_epc", EPCOut, 32'h0000_3004);

        idle(); EXLClr = 1; step(); idle();
        We = 1; A2 = 5'd12; DIn = 32'h0000_0801; step(); idle();
        HWInt = 6'h01;
        #1 chk("mask_req0", {31'd0, Req}, 32'd0);
        step();
        HWInt = 6'h02;
        #1 chk("mask_req1", {31'd0, Req}, 32'd1);
        step(); idle();
        ExcCodeIn = 5'd4;
        #1 chk("nest_req", {31'd0, Req}, 32'd0);
        step(); idle();

        We = 1; A2 = 5'd12; DIn = 32'h0000_FC03; EXLClr = 1;
        step(); idle();
        rd(5'd12, 32'h0000_FC01, "conf_sr");
        We = 1; A2 = 5'd14; DIn = 32'h0000_4007; step(); idle();
        #1 chk("mtc_epc", EPCOut, 32'h0000_4004);

        We = 1; A2 = 5'd14; DIn = 32'h1234_5678;
        ExcCodeIn = 5'd8; PC = 32'h0000_3020; BDIn = 0;
        step(); idle();
        #1 chk("sup_epc", EPCOut, 32'h0000_3020);

        EXLClr = 1; step(); idle();
        ExcCodeIn = 5'd5; reset = 0;
        step();
        reset = 1; idle();
        rd(5'd12, 32'h0000_FC00, "rr_sr");
        rd(5'd13, 32'h0000_0000, "rr_cause");
        chk("rr_epc", EPCOut, 32'h0000_0000);

        BDIn = 1; PC = 32'h0000_0000; ExcCodeIn = 5'd3;
        step(); idle();
        #1 chk("wrap_epc", EPCOut, 32'hFFFF_FFFC);

        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 39) != 0);
            ExcCodeIn = ($urandom_range(0, 3) == 0) ?
                        5'($urandom_range(1, 31)) : 5'd0;
            HWInt     = ($urandom_range(0, 2) == 0) ?
                        6'($urandom) : 6'd0;
            PC        = $urandom;
            BDIn      = 1'($urandom);
            We        = ($urandom_range(0, 2) == 0);
            A2        = 5'($urandom_range(10, 16));
            DIn       = $urandom;
            EXLClr    = ($urandom_range(0, 4) == 0);
            A1        = 5'($urandom_range(10, 17));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 block for the 5-stage MIPS pipeline. Holds SR, Cause, EPC and PRId.
- Arbitrates hardware interrupts and pipeline-reported exceptions, and produces the `Req` flush request consumed by every pipeline stage register. On `Req`, stage registers clear and inject PC `32'h0000_4180`.
- Sits beside the M stage. Services mfc0/mtc0, records victim PC and cause on entry, and clears EXL on eret.

Parameters:
- PRID_VAL, 32'h2021_0007, constant value returned for PRId (reg 15).
- IM_RESET, 6'b111111, reset value of SR.IM.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- A1  in  5  CP0 read address (mfc0 rd).
- A2  in  5  CP0 write address (mtc0 rd).
- DIn  in  32  mtc0 write data.
- We  in  1  mtc0 write enable.
- PC  in  32  PC of M-stage instruction (victim).
- BDIn  in  1  M-stage instruction is in a delay slot.
- ExcCodeIn  in  5  M-stage exception code; 0 = none.
- HWInt  in  6  external interrupt lines, level-sensitive.
- EXLClr  in  1  eret in M stage.
- Req  out  1  exception/interrupt taken this cycle.
- EPCOut  out  32  EPC register value.
- DOut  out  32  read data for A1.

Behaviour:
- Reset (clk edge with reset==0):
  - SR.IM=IM_RESET, SR.EXL=0, SR.IE=0 (reset asserts IE=0).
  - Cause=0, EPC=0.
  - Reset takes priority over `Req`, `We` and `EXLClr` in the same cycle.
  - During reset `Req` is forced 0.
- Register layout, with all unlisted bits reading 0:
  - SR(12): IM[15:10], EXL[1], IE[0].
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2].
  - EPC(14): [31:0], with bits [1:0] always 0.
  - PRId(15): PRID_VAL.
- Req (combinational, zero latency):
  - IntReq = |(HWInt & SR.IM) & SR.IE & !SR.EXL.
  - ExcReq = (ExcCodeIn!=0) & !SR.EXL.
  - Req = IntReq | ExcReq.
- On clk edge with Req=1:
  - EXL<=1.
  - ExcCode <= IntReq ? 0 : ExcCodeIn. Interrupt has priority over a simultaneous exception.
  - BD<=BDIn.
  - EPC <= (BDIn ? PC-4 : PC) with bits [1:0] cleared. Subtraction is 32-bit modulo: PC=0 with BD gives 32'hFFFF_FFFC.
- Cause.IP <= HWInt every cycle not in reset, regardless of Req or EXL.
- mtc0, applied at the clk edge when We=1, Req=0 and not in reset:
  - A2=12 writes IM, EXL and IE from DIn[15:10], DIn[1], DIn[0]; other bits are ignored.
  - A2=14 writes EPC <= {DIn[31:2],2'b00}.
  - Writes to 13, 15 or any other address have no effect.
- eret: when EXLClr=1 and Req=0, EXL<=0 at the clock edge.
- Same-cycle conflicts:
  - Req suppresses both We and EXLClr in the same cycle.
  - If We (to SR) and EXLClr coincide, EXLClr wins for the EXL bit; IM and IE still take DIn.
- DOut (combinational) for A1 in {12,13,14,15} returns the register value as stored before the pending edge, with no write-through forwarding. Any other A1 returns 0.
- EPCOut is the EPC register value, with no forwarding.
- Nested events: while EXL=1, interrupts and exceptions are masked and Req stays 0. Cause.IP continues to update.

Test Plan:
- Reset:
  - Stimulus: hold reset=0 two cycles, HWInt=6'h3F, ExcCodeIn=5'd4.
  - Required response: Req=0; DOut for A1=12 is 32'h0000_FC00, for A1=13 is 0, for A1=15 is PRID_VAL.
- Exception in delay slot:
  - Stimulus: SR=0 (IE=0), ExcCodeIn=5'd10, BDIn=1, PC=32'h0000_3010.
  - Required response: Req=1 same cycle. Next cycle EPCOut=32'h0000_300C, Cause=32'h8000_0028, SR.EXL=1, Req=0.
- Interrupt priority:
  - Stimulus: mtc0 SR=32'h0000_0401, then HWInt=6'h01 together with ExcCodeIn=5'd12, PC=32'h0000_3004.
  - Required response: Req=1; Cause.ExcCode=0, Cause.IP=6'h01, EPC=32'h0000_3004.
- Masking:
  - Stimulus: IM=6'h02, HWInt=6'h01, IE=1.
  - Required response: Req=0.
  - Stimulus: then HWInt=6'h02.
  - Required response: Req=1.
  - Stimulus: with EXL=1, pulse ExcCodeIn=4.
  - Required response: Req stays 0.
- eret and mtc0 conflict:
  - Stimulus: with EXL=1, assert We A2=12 DIn=32'h0000_FC03 together with EXLClr=1.
  - Required response: SR reads 32'h0000_FC01.
  - Stimulus: mtc0 EPC DIn=32'h0000_4007.
  - Required response: EPCOut=32'h0000_4004.
- Req suppresses write:
  - Stimulus: We=1 A2=14 DIn=32'h1234_5678 in the same cycle as ExcCodeIn=5'd8, PC=32'h0000_3020, BDIn=0.
  - Required response: EPC=32'h0000_3020.
  - Stimulus: reset=0 asserted in the same cycle as a Req.
  - Required response: all registers are at reset values afterwards.
